axi_id_remap: RTL and testbench

AXI_ID_REMAP -- requirements
Module: axi_id_remap

---
 rtl/axi_id_remap_pkg.sv | 11 +
 rtl/axi_bus.sv | 73 +++++++
 rtl/axi_id_remap_table.sv | 125 ++++++++++++
 rtl/axi_id_remap.sv | 123 ++++++++++++
 tb/tb_axi_id_remap.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_id_remap_pkg.sv
// Shared constants and helpers for the AXI ID remapper.
package axi_id_remap_pkg;

    localparam int unsigned DEFAULT_MAX_TXNS_PER_ID = 4;

    // Counter width able to hold 0..max_txns.
    function automatic int unsigned cnt_width(input int unsigned max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/axi_bus.sv
// Generic AXI4 bus bundle with master/slave views.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size, aw_prot;
    logic [1:0]                aw_burst;
    logic                      aw_lock, aw_valid, aw_ready;
    logic [3:0]                aw_cache, aw_qos, aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last, w_valid, w_ready;
    logic [AXI_USER_WIDTH-1:0] w_user;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid, b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size, ar_prot;
    logic [1:0]                ar_burst;
    logic                      ar_lock, ar_valid, ar_ready;
    logic [3:0]                ar_cache, ar_qos, ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last, r_valid, r_ready;
    logic [AXI_USER_WIDTH-1:0] r_user;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_id_remap_table.sv
// One direction of ID remapping: allocates narrow IDs to wide IDs and counts outstanding bursts.
// Optional SVA checks are compiled in with AXI_ID_REMAP_ASSERT_EN.
module axi_id_remap_table
    import axi_id_remap_pkg::*;
#(
    parameter int unsigned ID_IN_WIDTH = 6,
    parameter int unsigned IDX_WIDTH   = 2,
    parameter int unsigned MAX_TXNS    = DEFAULT_MAX_TXNS_PER_ID
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    input  logic                   req_ready_i,
    input  logic [ID_IN_WIDTH-1:0] req_id_i,
    output logic                   req_go_c_o,
    output logic [IDX_WIDTH-1:0]   req_idx_c_o,
    input  logic                   rsp_valid_i,
    input  logic                   rsp_ready_i,
    input  logic                   rsp_last_i,
    input  logic [IDX_WIDTH-1:0]   rsp_idx_i,
    output logic [ID_IN_WIDTH-1:0] rsp_id_c_o
);
    localparam int unsigned        NUM_ENTRIES = 2 ** IDX_WIDTH;
    localparam int unsigned        CNT_WIDTH   = cnt_width(MAX_TXNS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_TXNS);

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [ID_IN_WIDTH-1:0] id_q  [NUM_ENTRIES];
    logic [ID_IN_WIDTH-1:0] id_d  [NUM_ENTRIES];
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_ENTRIES];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_ENTRIES];
    logic                   pend_q, pend_d;
    logic [IDX_WIDTH-1:0]   pend_idx_q, pend_idx_d;
    logic                   hit, free, alloc, rel;
    logic [IDX_WIDTH-1:0]   hit_idx, free_idx;

    assign alloc      = req_valid_i & req_ready_i & req_go_c_o;
    assign rel        = rsp_valid_i & rsp_ready_i & rsp_last_i;
    assign rsp_id_c_o = id_q[rsp_idx_i];

    // Lookup; a request already offered downstream keeps its index until accepted.
    always_comb begin
        hit         = 1'b0;
        hit_idx     = '0;
        free        = 1'b0;
        free_idx    = '0;
        req_go_c_o  = 1'b0;
        req_idx_c_o = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && valid_q[i] && id_q[i] == req_id_i) begin
                hit     = 1'b1;
                hit_idx = IDX_WIDTH'(i);
            end
            if (!free && !valid_q[i]) begin
                free     = 1'b1;
                free_idx = IDX_WIDTH'(i);
            end
        end
        if (pend_q) begin
            req_go_c_o  = 1'b1;
            req_idx_c_o = pend_idx_q;
        end else if (hit) begin
            req_go_c_o  = (cnt_q[hit_idx] != CNT_MAX);
            req_idx_c_o = hit_idx;
        end else if (free) begin
            req_go_c_o  = 1'b1;
            req_idx_c_o = free_idx;
        end
    end

    always_comb begin
        pend_d     = 1'b0;
        pend_idx_d = pend_idx_q;
        valid_d    = valid_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        if (req_valid_i && req_go_c_o && !req_ready_i) begin
            pend_d     = 1'b1;
            pend_idx_d = req_idx_c_o;
        end
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc && req_idx_c_o == IDX_WIDTH'(i)) begin
                id_d[i]    = req_id_i;
                valid_d[i] = 1'b1;
                if (!(rel && rsp_idx_i == IDX_WIDTH'(i))) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end else if (rel && rsp_idx_i == IDX_WIDTH'(i)) begin
                cnt_d[i]   = cnt_q[i] - CNT_WIDTH'(1);
                valid_d[i] = (cnt_q[i] != CNT_WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                id_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef AXI_ID_REMAP_ASSERT_EN
    a_rsp_valid_entry: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid_i |-> valid_q[rsp_idx_i])
        else $error("axi_id_remap: response for invalid entry %0d", rsp_idx_i);
    a_cnt_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (alloc && !(rel && rsp_idx_i == req_idx_c_o)) |-> cnt_q[req_idx_c_o] != CNT_MAX)
        else $error("axi_id_remap: count overflow on entry %0d", req_idx_c_o);
    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        rel |-> cnt_q[rsp_idx_i] != '0)
        else $error("axi_id_remap: count underflow on entry %0d", rsp_idx_i);
`endif

endmodule

// File: rtl/axi_id_remap.sv
// Remaps wide crossbar AXI IDs onto a narrow ID space with per-ID outstanding tracking.
// Define AXI_ID_REMAP_ASSERT_EN to compile in protocol/table SVA checks.
module axi_id_remap
    import axi_id_remap_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned AXI_USER_WIDTH   = 6,
    parameter int unsigned AXI_ID_IN_WIDTH  = 6,
    parameter int unsigned AXI_ID_OUT_WIDTH = 2,
    parameter int unsigned MAX_TXNS_PER_ID  = DEFAULT_MAX_TXNS_PER_ID
) (
    input logic  clk_i,
    input logic  rst_i,
    AXI_BUS.Slave  slave,
    AXI_BUS.Master master
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic                        aw_go, ar_go;
    logic [AXI_ID_OUT_WIDTH-1:0] aw_idx, ar_idx;
    logic [AXI_ID_IN_WIDTH-1:0]  b_id_in, r_id_in;

    axi_id_remap_table #(
        .ID_IN_WIDTH (AXI_ID_IN_WIDTH),
        .IDX_WIDTH   (AXI_ID_OUT_WIDTH),
        .MAX_TXNS    (MAX_TXNS_PER_ID)
    ) i_wr_table (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (slave.aw_valid),
        .req_ready_i (master.aw_ready),
        .req_id_i    (slave.aw_id),
        .req_go_c_o  (aw_go),
        .req_idx_c_o (aw_idx),
        .rsp_valid_i (master.b_valid),
        .rsp_ready_i (slave.b_ready),
        .rsp_last_i  (1'b1),
        .rsp_idx_i   (master.b_id),
        .rsp_id_c_o  (b_id_in)
    );

    axi_id_remap_table #(
        .ID_IN_WIDTH (AXI_ID_IN_WIDTH),
        .IDX_WIDTH   (AXI_ID_OUT_WIDTH),
        .MAX_TXNS    (MAX_TXNS_PER_ID)
    ) i_rd_table (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (slave.ar_valid),
        .req_ready_i (master.ar_ready),
        .req_id_i    (slave.ar_id),
        .req_go_c_o  (ar_go),
        .req_idx_c_o (ar_idx),
        .rsp_valid_i (master.r_valid),
        .rsp_ready_i (slave.r_ready),
        .rsp_last_i  (master.r_last),
        .rsp_idx_i   (master.r_id),
        .rsp_id_c_o  (r_id_in)
    );

    // AW: only the ID changes; a stalled request is hidden from both sides.
    assign master.aw_id     = aw_idx;
    assign master.aw_addr   = AXI_ADDR_WIDTH'(slave.aw_addr);
    assign master.aw_len    = slave.aw_len;
    assign master.aw_size   = slave.aw_size;
    assign master.aw_burst  = slave.aw_burst;
    assign master.aw_lock   = slave.aw_lock;
    assign master.aw_cache  = slave.aw_cache;
    assign master.aw_prot   = slave.aw_prot;
    assign master.aw_qos    = slave.aw_qos;
    assign master.aw_region = slave.aw_region;
    assign master.aw_user   = AXI_USER_WIDTH'(slave.aw_user);
    assign master.aw_valid  = slave.aw_valid & aw_go;
    assign slave.aw_ready   = master.aw_ready & aw_go;

    assign master.w_data    = AXI_DATA_WIDTH'(slave.w_data);
    assign master.w_strb    = STRB_WIDTH'(slave.w_strb);
    assign master.w_last    = slave.w_last;
    assign master.w_user    = AXI_USER_WIDTH'(slave.w_user);
    assign master.w_valid   = slave.w_valid;
    assign slave.w_ready    = master.w_ready;

    assign slave.b_id       = b_id_in;
    assign slave.b_resp     = master.b_resp;
    assign slave.b_user     = AXI_USER_WIDTH'(master.b_user);
    assign slave.b_valid    = master.b_valid;
    assign master.b_ready   = slave.b_ready;

    assign master.ar_id     = ar_idx;
    assign master.ar_addr   = AXI_ADDR_WIDTH'(slave.ar_addr);
    assign master.ar_len    = slave.ar_len;
    assign master.ar_size   = slave.ar_size;
    assign master.ar_burst  = slave.ar_burst;
    assign master.ar_lock   = slave.ar_lock;
    assign master.ar_cache  = slave.ar_cache;
    assign master.ar_prot   = slave.ar_prot;
    assign master.ar_qos    = slave.ar_qos;
    assign master.ar_region = slave.ar_region;
    assign master.ar_user   = AXI_USER_WIDTH'(slave.ar_user);
    assign master.ar_valid  = slave.ar_valid & ar_go;
    assign slave.ar_ready   = master.ar_ready & ar_go;

    assign slave.r_id       = r_id_in;
    assign slave.r_data     = AXI_DATA_WIDTH'(master.r_data);
    assign slave.r_resp     = master.r_resp;
    assign slave.r_last     = master.r_last;
    assign slave.r_user     = AXI_USER_WIDTH'(master.r_user);
    assign slave.r_valid    = master.r_valid;
    assign master.r_ready   = slave.r_ready;

`ifdef AXI_ID_REMAP_ASSERT_EN
    a_aw_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (master.aw_valid && !master.aw_ready) |=>
            (master.aw_valid && $stable(master.aw_id) && $stable(master.aw_addr)))
        else $error("axi_id_remap: AW changed while stalled");
    a_ar_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (master.ar_valid && !master.ar_ready) |=>
            (master.ar_valid && $stable(master.ar_id) && $stable(master.ar_addr)))
        else $error("axi_id_remap: AR changed while stalled");
`endif

endmodule

// File: tb/tb_axi_id_remap.sv
// Self-checking bench for axi_id_remap: vector table plus multi-cycle corner sequences.
module tb_axi_id_remap;
    localparam int unsigned AW = 32, DW = 64, UW = 6, IW = 6, OW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) s_bus ();
    AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(OW), .AXI_USER_WIDTH(UW)) m_bus ();

    axi_id_remap #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW),
        .AXI_ID_IN_WIDTH(IW), .AXI_ID_OUT_WIDTH(OW), .MAX_TXNS_PER_ID(4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .slave (s_bus),
        .master(m_bus)
    );

    int total = 0;
    int bad   = 0;
    logic [IW-1:0] wsb [4][$];
    logic [IW-1:0] rsb [4][$];

    typedef struct packed {
        logic          is_b;
        logic [IW-1:0] id;
        logic          ok;
        logic [OW-1:0] idx;
    } wvec_t;
    wvec_t vec [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_set(input logic [IW-1:0] id);
        s_bus.aw_valid = 1'b1;
        s_bus.aw_id    = id;
        s_bus.aw_addr  = $urandom;
        s_bus.aw_len   = 8'(id);
    endtask

    task automatic aw_chk(input logic [IW-1:0] id, input logic ok, input logic [OW-1:0] idx);
        chk("aw_valid", 64'(m_bus.aw_valid), 64'(ok));
        chk("aw_ready", 64'(s_bus.aw_ready), 64'(ok & m_bus.aw_ready));
        if (ok) begin
            chk("aw_id", 64'(m_bus.aw_id), 64'(idx));
            chk("aw_len", 64'(m_bus.aw_len), 64'(id));
            if (m_bus.aw_ready) wsb[idx].push_back(id);
        end
    endtask

    task automatic b_set(input logic [OW-1:0] idx);
        m_bus.b_valid = 1'b1;
        m_bus.b_id    = idx;
        m_bus.b_resp  = 2'b10;
    endtask

    task automatic b_chk(input logic [OW-1:0] idx);
        chk("b_valid", 64'(s_bus.b_valid), 64'(1));
        chk("b_resp", 64'(s_bus.b_resp), 64'(2'b10));
        if (wsb[idx].size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_sb: got B on idx %0d want none outstanding", idx);
        end else begin
            chk("b_id", 64'(s_bus.b_id), 64'(wsb[idx].pop_front()));
        end
    endtask

    task automatic aw_beat(input logic [IW-1:0] id, input logic ok, input logic [OW-1:0] idx);
        aw_set(id);
        #2;
        aw_chk(id, ok, idx);
        step();
        s_bus.aw_valid = 1'b0;
    endtask

    task automatic b_beat(input logic [OW-1:0] idx);
        b_set(idx);
        #2;
        b_chk(idx);
        step();
        m_bus.b_valid = 1'b0;
    endtask

    // Request stalled while a release lands; it must go through the following cycle.
    task automatic aw_release_seq(input logic [IW-1:0] id, input logic [OW-1:0] bidx,
                                  input logic [OW-1:0] exp_idx);
        aw_set(id);
        b_set(bidx);
        #2;
        aw_chk(id, 1'b0, exp_idx);
        b_chk(bidx);
        step();
        m_bus.b_valid = 1'b0;
        #2;
        aw_chk(id, 1'b1, exp_idx);
        step();
        s_bus.aw_valid = 1'b0;
    endtask

    task automatic ar_set(input logic [IW-1:0] id);
        s_bus.ar_valid = 1'b1;
        s_bus.ar_id    = id;
        s_bus.ar_addr  = $urandom;
    endtask

    task automatic ar_chk(input logic [IW-1:0] id, input logic ok, input logic [OW-1:0] idx);
        chk("ar_valid", 64'(m_bus.ar_valid), 64'(ok));
        chk("ar_ready", 64'(s_bus.ar_ready), 64'(ok));
        if (ok) begin
            chk("ar_id", 64'(m_bus.ar_id), 64'(idx));
            rsb[idx].push_back(id);
        end
    endtask

    task automatic r_set(input logic [OW-1:0] idx, input logic last, input logic [DW-1:0] d);
        m_bus.r_valid = 1'b1;
        m_bus.r_id    = idx;
        m_bus.r_last  = last;
        m_bus.r_data  = d;
    endtask

    task automatic r_chk(input logic [OW-1:0] idx, input logic last, input logic [DW-1:0] d);
        chk("r_data", s_bus.r_data, d);
        chk("r_last", 64'(s_bus.r_last), 64'(last));
        if (rsb[idx].size() == 0) begin
            total++;
            bad++;
            $display("FAIL r_sb: got R on idx %0d want none outstanding", idx);
        end else begin
            chk("r_id", 64'(s_bus.r_id), 64'(rsb[idx][0]));
            if (last) void'(rsb[idx].pop_front());
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        rst = 1'b1;
        s_bus.aw_valid = 1'b0; s_bus.aw_id = '0; s_bus.aw_addr = '0; s_bus.aw_len = '0;
        s_bus.aw_size = 3'd3; s_bus.aw_burst = 2'd1; s_bus.aw_lock = 1'b0; s_bus.aw_cache = '0;
        s_bus.aw_prot = '0; s_bus.aw_qos = '0; s_bus.aw_region = '0; s_bus.aw_user = '0;
        s_bus.ar_valid = 1'b0; s_bus.ar_id = '0; s_bus.ar_addr = '0; s_bus.ar_len = '0;
        s_bus.ar_size = 3'd3; s_bus.ar_burst = 2'd1; s_bus.ar_lock = 1'b0; s_bus.ar_cache = '0;
        s_bus.ar_prot = '0; s_bus.ar_qos = '0; s_bus.ar_region = '0; s_bus.ar_user = '0;
        s_bus.w_valid = 1'b0; s_bus.w_data = '0; s_bus.w_strb = '0; s_bus.w_last = 1'b0;
        s_bus.w_user = '0; s_bus.b_ready = 1'b1; s_bus.r_ready = 1'b1;
        m_bus.aw_ready = 1'b1; m_bus.ar_ready = 1'b1; m_bus.w_ready = 1'b1;
        m_bus.b_valid = 1'b0; m_bus.b_id = '0; m_bus.b_resp = '0; m_bus.b_user = '0;
        m_bus.r_valid = 1'b0; m_bus.r_id = '0; m_bus.r_data = '0; m_bus.r_resp = '0;
        m_bus.r_last = 1'b0; m_bus.r_user = '0;

        vec[0]  = '{1'b0, 6'h2A, 1'b1, 2'd0};
        vec[1]  = '{1'b0, 6'h15, 1'b1, 2'd1};
        vec[2]  = '{1'b1, 6'h00, 1'b1, 2'd1};
        vec[3]  = '{1'b1, 6'h00, 1'b1, 2'd0};
        vec[4]  = '{1'b0, 6'h07, 1'b1, 2'd0};
        vec[5]  = '{1'b0, 6'h07, 1'b1, 2'd0};
        vec[6]  = '{1'b0, 6'h07, 1'b1, 2'd0};
        vec[7]  = '{1'b0, 6'h07, 1'b1, 2'd0};
        vec[8]  = '{1'b0, 6'h07, 1'b0, 2'd0};
        vec[9]  = '{1'b1, 6'h00, 1'b1, 2'd0};
        vec[10] = '{1'b0, 6'h07, 1'b1, 2'd0};
        vec[11] = '{1'b0, 6'h10, 1'b1, 2'd1};
        vec[12] = '{1'b0, 6'h11, 1'b1, 2'd2};
        vec[13] = '{1'b0, 6'h12, 1'b1, 2'd3};
        vec[14] = '{1'b0, 6'h13, 1'b0, 2'd0};
        vec[15] = '{1'b0, 6'h12, 1'b1, 2'd3};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_aw_valid", 64'(m_bus.aw_valid), 64'(0));
        chk("rst_ar_valid", 64'(m_bus.ar_valid), 64'(0));
        step();

        for (int i = 0; i < 16; i++) begin
            if (vec[i].is_b) b_beat(vec[i].idx);
            else             aw_beat(vec[i].id, vec[i].ok, vec[i].idx);
        end

        // Entry 0 full with ID 0x07: stall persists through the releasing cycle.
        aw_release_seq(6'h07, 2'd0, 2'd0);

        // Allocate and release on entry 1 (count 1) in the same cycle.
        aw_set(6'h10);
        b_set(2'd1);
        #2;
        aw_chk(6'h10, 1'b1, 2'd1);
        b_chk(2'd1);
        step();
        s_bus.aw_valid = 1'b0;
        m_bus.b_valid  = 1'b0;
        aw_beat(6'h3E, 1'b0, 2'd0);
        aw_release_seq(6'h3F, 2'd1, 2'd1);

        // W passthrough, including backpressure.
        d = {$urandom, $urandom};
        s_bus.w_valid = 1'b1; s_bus.w_data = d; s_bus.w_strb = 8'hA5; s_bus.w_last = 1'b1;
        m_bus.w_ready = 1'b0;
        #2;
        chk("w_data", m_bus.w_data, d);
        chk("w_strb", 64'(m_bus.w_strb), 64'(8'hA5));
        chk("w_valid", 64'(m_bus.w_valid), 64'(1));
        chk("w_ready", 64'(s_bus.w_ready), 64'(0));
        step();
        s_bus.w_valid = 1'b0; m_bus.w_ready = 1'b1;

        // Reset with writes outstanding discards all tracking.
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) wsb[i].delete();
        step();
        aw_beat(6'h07, 1'b1, 2'd0);
        aw_beat(6'h08, 1'b1, 2'd1);

        // Offered request keeps its index even if its entry frees while waiting.
        b_beat(2'd0);
        m_bus.aw_ready = 1'b0;
        aw_set(6'h08);
        b_set(2'd1);
        #2;
        aw_chk(6'h08, 1'b1, 2'd1);
        b_chk(2'd1);
        step();
        m_bus.b_valid = 1'b0;
        #2;
        chk("hold_aw_valid", 64'(m_bus.aw_valid), 64'(1));
        chk("hold_aw_id", 64'(m_bus.aw_id), 64'(1));
        m_bus.aw_ready = 1'b1;
        #1;
        aw_chk(6'h08, 1'b1, 2'd1);
        step();
        s_bus.aw_valid = 1'b0;
        aw_beat(6'h09, 1'b1, 2'd0);

        // Read table: fill, stall a fifth ID, release via a 4-beat burst.
        for (int i = 0; i < 4; i++) begin
            ar_set(6'(i + 1));
            #2;
            ar_chk(6'(i + 1), 1'b1, 2'(i));
            step();
            s_bus.ar_valid = 1'b0;
        end
        ar_set(6'h05);
        for (int b = 0; b < 4; b++) begin
            d = {$urandom, $urandom};
            r_set(2'd2, (b == 3), d);
            #2;
            ar_chk(6'h05, 1'b0, 2'd0);
            r_chk(2'd2, (b == 3), d);
            step();
        end
        m_bus.r_valid = 1'b0;
        m_bus.r_last  = 1'b0;
        #2;
        ar_chk(6'h05, 1'b1, 2'd2);
        step();
        s_bus.ar_valid = 1'b0;
        d = {$urandom, $urandom};
        r_set(2'd2, 1'b1, d);
        #2;
        r_chk(2'd2, 1'b1, d);
        step();
        m_bus.r_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
